// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the serial receive path: deserializer state
// encoding and the bit-order constants agreed with the serializer.
package sipo_deser_pkg;

    // Bit-order select values; serializer left shift == MSB first.
    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

    // Deserializer frame state: IDLE holds no bits, SHIFT holds 1..WIDTH-1.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage : sipo_deser_pkg

// File: rtl/sipo_out_reg.sv
// Output holding register with valid/ready handshake and sticky overrun.
// A completed word is taken when the register is empty or being drained on
// the same edge; otherwise it is dropped and overrun is flagged.
module sipo_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    logic accept;

    // Room for a new word: empty, or the held word leaves on this edge.
    assign accept = !dout_valid || dout_ready;

    // Holding register, handshake flag and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (clr) begin
            // The last word value is kept for inspection; only flags clear.
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            if (accept) begin
                dout       <= din;
                dout_valid <= 1'b1;
            end else begin
                overrun    <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule : sipo_out_reg

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer. Collects WIDTH strobed bits in the
// selected order and hands each completed word to sipo_out_reg.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             bit_en,
    input  logic             sel,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int              CNTW     = $clog2(WIDTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CNTW-1:0]  cnt;
    logic             sel_lat;
    logic             order;
    logic             word_done;

    // The first bit of a word follows live sel; later bits follow the latch.
    assign order     = (state == IDLE) ? sel : sel_lat;
    assign word_done = bit_en && !sync_clr && (cnt == CNT_LAST);
    assign busy      = (state == SHIFT);

    // Shift candidate including the current serial bit.
    always_comb begin
        // NOTE: default first so no path leaves sr_next unassigned (no latch).
        sr_next = sr;
        if (order == LSB_FIRST) begin
            sr_next = {sin, sr[WIDTH-1:1]};
        end else begin
            sr_next = {sr[WIDTH-2:0], sin};
        end
    end

    // Frame FSM with bit counter, shift register and order latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            sel_lat <= MSB_FIRST;
        end else if (sync_clr) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (bit_en) begin
            sr <= sr_next;
            if (state == IDLE) begin
                sel_lat <= sel;
            end
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                state <= IDLE;
            end else begin
                cnt   <= cnt + 1'b1;
                state <= SHIFT;
            end
        end
    end

    sipo_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (word_done),
        .din       (sr_next),
        .clr       (sync_clr),
        .dout_ready(dout_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .overrun   (overrun)
    );

endmodule : sipo_deser

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: table-driven words, hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_sipo_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         sin;
    logic         bit_en;
    logic         sel;
    logic         sync_clr;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         overrun;

    int tests = 0;
    int fails = 0;

    sipo_deser #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .bit_en    (bit_en),
        .sel       (sel),
        .sync_clr  (sync_clr),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] seq;     // seq[W-1] is sent first
        logic         order;
        int           max_gap;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send bits seq[W-1-first] .. seq[W-1-(first+n-1)] back to back.
    task automatic send_bits(input logic [W-1:0] seq, input logic s, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            sel    = s;
            sin    = seq[W-1-i];
            bit_en = 1'b1;
            step();
            bit_en = 1'b0;
        end
    endtask

    // Model state for the randomized phase.
    logic q_bits[$];
    logic m_order;
    logic [W-1:0] m_dout;
    logic m_valid;
    logic m_ovr;

    function automatic logic [W-1:0] assemble(input logic ord);
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (ord) w = w | (W'(q_bits[i]) << i);
            else     w = w | (W'(q_bits[i]) << (W - 1 - i));
        end
        return w;
    endfunction

    initial begin
        vecs[0] = '{8'h12, 1'b0, 0, 8'h12};
        vecs[1] = '{8'h12, 1'b1, 0, 8'h48};
        vecs[2] = '{8'hA7, 1'b0, 5, 8'hA7};
        vecs[3] = '{8'h3C, 1'b1, 2, 8'h3C};
        vecs[4] = '{8'h01, 1'b1, 0, 8'h80};
        vecs[5] = '{8'hFF, 1'b0, 3, 8'hFF};
        vecs[6] = '{8'h80, 1'b0, 1, 8'h80};

        reset = 1'b0; sin = 1'b0; bit_en = 1'b0; sel = 1'b0;
        sync_clr = 1'b0; dout_ready = 1'b0;
        #1;
        check("reset_dout", dout, 0);
        check("reset_valid", dout_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        repeat (2) step();
        reset = 1'b1;
        step();

        // Table-driven words, optionally with gaps between strobes.
        foreach (vecs[v]) begin
            dout_ready = 1'b1;
            step();
            dout_ready = 1'b0;
            check("tbl_pre_valid", dout_valid, 0);
            for (int i = 0; i < W; i++) begin
                sel    = vecs[v].order;
                sin    = vecs[v].seq[W-1-i];
                bit_en = 1'b1;
                step();
                bit_en = 1'b0;
                if (i < W - 1) begin
                    check("tbl_busy_mid", busy, 1);
                    check("tbl_valid_mid", dout_valid, 0);
                    repeat ($urandom_range(vecs[v].max_gap, 0)) begin
                        step();
                        check("tbl_valid_gap", dout_valid, 0);
                    end
                end
            end
            check("tbl_dout", dout, vecs[v].exp);
            check("tbl_valid", dout_valid, 1);
            check("tbl_busy_end", busy, 0);
        end
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;

        // sel changes mid-word are ignored until the next word.
        send_bits(8'h12, 1'b1, 0, 3);
        send_bits(8'h12, 1'b0, 3, 5);
        check("selflip_dout", dout, 8'h48);
        check("selflip_valid", dout_valid, 1);

        // Backpressure: second word dropped, overrun sticky.
        dout_ready = 1'b1; step(); dout_ready = 1'b0;
        send_bits(8'h12, 1'b0, 0, W);
        send_bits(8'h34, 1'b0, 0, W);
        check("bp_dout", dout, 8'h12);
        check("bp_valid", dout_valid, 1);
        check("bp_overrun", overrun, 1);
        dout_ready = 1'b1; step(); dout_ready = 1'b0;
        check("bp_drain_valid", dout_valid, 0);
        check("bp_overrun_sticky", overrun, 1);
        repeat (3) step();
        check("bp_overrun_hold", overrun, 1);
        sync_clr = 1'b1; step(); sync_clr = 1'b0;
        check("bp_overrun_clr", overrun, 0);
        check("bp_dout_kept", dout, 8'h12);

        // Back-to-back: ready only on the completing edge of 0x55.
        send_bits(8'h12, 1'b0, 0, W);
        send_bits(8'h55, 1'b0, 0, W - 1);
        check("b2b_hold", dout, 8'h12);
        dout_ready = 1'b1;
        send_bits(8'h55, 1'b0, W - 1, 1);
        dout_ready = 1'b0;
        check("b2b_dout", dout, 8'h55);
        check("b2b_valid", dout_valid, 1);
        check("b2b_overrun", overrun, 0);

        // sync_clr after 5 bits, with a coincident ignored strobe.
        send_bits(8'hFF, 1'b0, 0, 5);
        check("clr_busy_before", busy, 1);
        sync_clr = 1'b1; bit_en = 1'b1; sin = 1'b1;
        step();
        sync_clr = 1'b0; bit_en = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_valid", dout_valid, 0);
        check("clr_dout_kept", dout, 8'h55);
        send_bits(8'h3C, 1'b0, 0, W);
        check("clr_next_dout", dout, 8'h3C);
        check("clr_next_valid", dout_valid, 1);

        // Asynchronous reset mid-word.
        send_bits(8'hF0, 1'b0, 0, 3);
        #2 reset = 1'b0;
        #1;
        check("arst_dout", dout, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        step();
        reset = 1'b1;
        step();
        send_bits(8'hA7, 1'b0, 0, W);
        check("arst_next_dout", dout, 8'hA7);
        check("arst_next_valid", dout_valid, 1);

        // Randomized traffic against the reference model.
        reset = 1'b0; #2; reset = 1'b1;
        q_bits.delete();
        m_order = 1'b0; m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic xfer;
            bit_en     = ($urandom_range(2, 0) != 0);
            sin        = 1'($urandom);
            sel        = 1'($urandom);
            dout_ready = ($urandom_range(3, 0) == 0);
            sync_clr   = ($urandom_range(99, 0) == 0);
            xfer = m_valid && dout_ready;
            if (sync_clr) begin
                q_bits.delete();
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end else if (bit_en) begin
                if (q_bits.size() == 0) m_order = sel;
                q_bits.push_back(sin);
                if (q_bits.size() == W) begin
                    if (!m_valid || dout_ready) begin
                        m_dout  = assemble(m_order);
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                    q_bits.delete();
                end else if (xfer) begin
                    m_valid = 1'b0;
                end
            end else if (xfer) begin
                m_valid = 1'b0;
            end
            step();
            check("rnd_dout", dout, m_dout);
            check("rnd_valid", dout_valid, m_valid);
            check("rnd_busy", busy, q_bits.size() != 0);
            check("rnd_overrun", overrun, m_ovr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sipo_deser

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in/parallel-out deserializer. Receive-side counterpart of the team's parallel-load left/right shift register used as a serializer.
- Collects WIDTH serial bits, qualified by a bit strobe, into one word. Bit order is selectable: MSB-first matches serializer left-shift, LSB-first matches right-shift.
- Presents each completed word on a valid/ready output port with sticky overrun detection.
- Sits between a serial link/shift-out stage and byte-wide consumer logic.

Parameters:
- WIDTH, 8, word length in bits; must be >= 2.
- CNTW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sin  input  1  serial data bit.
- bit_en  input  1  bit strobe; sin sampled on edges where bit_en=1.
- sel  input  1  bit order: 0 = MSB-first (left shift in), 1 = LSB-first (right shift in).
- sync_clr  input  1  synchronous frame restart; discards the partial word.
- dout  output  WIDTH  last completed word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1.
- busy  output  1  a partial word is in progress (state SHIFT).
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (reset=0, async): sr=0, cnt=0, sel_lat=0, state=IDLE, dout=0, dout_valid=0, overrun=0, busy=0.
- FSM states:
  - IDLE: cnt=0, no partial word.
  - SHIFT: 1..WIDTH-1 bits held.
  - IDLE->SHIFT on bit_en.
  - SHIFT->IDLE on the WIDTH-th bit_en, or on sync_clr.
- Order latch: sel is sampled into sel_lat on the first bit_en of a word, i.e. in IDLE. Changes to sel during SHIFT are ignored until the next word.
- Shift on bit_en:
  - sel_lat=0: sr <= {sr[WIDTH-2:0], sin}. The first bit lands in the MSB.
  - sel_lat=1: sr <= {sin, sr[WIDTH-1:1]}. The first bit lands in the LSB.
  - The first bit uses the live sel value, not the stale sel_lat.
- cnt increments per bit_en; on the bit where cnt==WIDTH-1, cnt wraps to 0 and the word completes.
- Word completion: the assembled word, including the current bit, is the candidate. It is loaded into dout in the same edge and dout_valid=1 is visible in the next cycle, i.e. zero extra latency after the last bit edge.
- Output handshake:
  - Transfer occurs on an edge where dout_valid=1 and dout_ready=1; dout_valid then clears unless a new word completes on that same edge.
  - dout is stable while dout_valid=1 and not transferred.
  - dout_ready while dout_valid=0 has no effect.
- Completion cases:
  - dout_valid=0: load the word, set valid.
  - dout_valid=1 and dout_ready=1: load the new word, valid stays 1, no overrun.
  - dout_valid=1 and dout_ready=0: new word dropped, dout unchanged, overrun<=1.
- overrun is sticky; cleared only by reset or sync_clr.
- sync_clr priority is above bit_en:
  - Clears sr, cnt, overrun, dout_valid; forces IDLE.
  - dout value is retained.
  - A coincident bit_en is ignored.
- busy = (state==SHIFT); combinational from state, no glitch source beyond registers.
- bit_en gaps of any length inside a word are legal; the partial word is held indefinitely.
- Reset mid-word: immediate return to reset values; the partial word is lost.

Decomposition:
- No shared package needed beyond a local state enum (IDLE, SHIFT). If the team's serial-link package exists, place the order constants MSB_FIRST=1'b0 and LSB_FIRST=1'b1 there so serializer and deserializer agree.
- One natural sub-module: sipo_out_reg, the WIDTH-bit holding register with valid/ready and overrun logic, reusable by other receive blocks.
- Shifter and counter stay in the top module.

Test Plan:
- MSB-first: sel=0, bits 0,0,0,1,0,0,1,0 on 8 consecutive bit_en.
  - dout=0x12 and dout_valid=1 the cycle after the 8th edge.
  - busy=1 from the 1st through 7th bit, 0 after.
- LSB-first: sel=1, same bit sequence -> dout=0x48.
  - Flipping sel to 0 after bit 3 still yields 0x48.
- Gapped strobes: bits of 0xA7 MSB-first, with 0-5 idle cycles between bit_en pulses -> dout=0xA7; no early dout_valid.
- Backpressure and overrun: dout_ready=0; send 0x12 then 0x34 -> dout remains 0x12, overrun=1.
  - Raise dout_ready -> dout_valid drops next cycle; overrun stays 1 until sync_clr.
- Back-to-back completion: dout_valid=1 holding 0x12, with dout_ready=1 on the edge where 0x55 completes -> dout=0x55, dout_valid stays 1, overrun=0.
- Restart/reset:
  - sync_clr after 5 bits, then a full 0x3C -> dout=0x3C and dout_valid cleared by sync_clr.
  - reset=0 asserted mid-word -> all outputs 0 immediately, asynchronously; the next full word decodes correctly.
